// File: rtl/hram_mmio_responder_if.sv
// CPU bus bundle for hram_mmio_responder: strobes, address, write data,
// combinational read data and claim flag.
`timescale 1ns/1ps
interface hram_mmio_responder_if;
  logic        rd_en;
  logic        wr_en;
  logic [15:0] addr_in;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        hit;

  modport master (
    output rd_en, wr_en, addr_in, data_in,
    input  data_out, hit
  );

  modport slave (
    input  rd_en, wr_en, addr_in, data_in,
    output data_out, hit
  );
endinterface

// File: rtl/hram_mmio_responder.sv
// High I/O page responder: DIV/TIMA/TMA/TAC timer, IF/IE interrupt registers
// and (when HRAM_EN is defined) 127 bytes of high RAM at FF80-FFFE.
// Read data is combinational so the CPU can sample it on the closing edge.
`timescale 1ns/1ps
module hram_mmio_responder #(
  parameter logic [15:0] DIV_INIT = 16'h0000,
  parameter logic [4:0]  IF_INIT  = 5'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  hram_mmio_responder_if.slave  bus,
  input  logic [4:0]            irq_set,
  input  logic [4:0]            irq_ack,
  output logic [4:0]            irq_pending
);

  logic [15:0] div;
  logic [7:0]  tima;
  logic [7:0]  tma;
  logic [2:0]  tac;
  logic [4:0]  if_q;
  logic [7:0]  ie;
  logic        ovf_pend;
  logic        term_q;

  logic is_div, is_tima, is_tma, is_tac, is_if, is_ie, is_hram;
  logic wr_div, wr_tima, wr_tma, wr_tac, wr_if, wr_ie;
  logic claimed;
  logic [7:0] rdata;
  logic [7:0] hram_rdata;
  logic sel_bit, tmr_term, tick, timer_irq;
  logic [4:0] hw_set, if_next;
  logic unused_irq_set2;

  // irq_set[2] has no function: the timer interrupt is generated internally.
  assign unused_irq_set2 = irq_set[2];

  // Register address decode and per-register write strobes.
  always_comb begin
    is_div  = (bus.addr_in == 16'hFF04);
    is_tima = (bus.addr_in == 16'hFF05);
    is_tma  = (bus.addr_in == 16'hFF06);
    is_tac  = (bus.addr_in == 16'hFF07);
    is_if   = (bus.addr_in == 16'hFF0F);
    is_ie   = (bus.addr_in == 16'hFFFF);
    wr_div  = bus.wr_en & is_div;
    wr_tima = bus.wr_en & is_tima;
    wr_tma  = bus.wr_en & is_tma;
    wr_tac  = bus.wr_en & is_tac;
    wr_if   = bus.wr_en & is_if;
    wr_ie   = bus.wr_en & is_ie;
  end

`ifdef HRAM_EN
  logic [7:0] hram [0:126];

  assign is_hram    = (bus.addr_in[15:7] == 9'h1FF) && (bus.addr_in[6:0] != 7'h7F);
  assign hram_rdata = hram[bus.addr_in[6:0]];

  // High RAM storage: no reset, contents undefined after power-up.
  always_ff @(posedge clk) begin
    if (bus.wr_en && is_hram && !rst)
      hram[bus.addr_in[6:0]] <= bus.data_in;
  end
`else
  assign is_hram    = 1'b0;
  assign hram_rdata = '1;
`endif

  // Read mux from current register state; unclaimed addresses read FF.
  always_comb begin
    claimed = 1'b1;
    rdata   = '1;
    if (is_div)       rdata = div[15:8];
    else if (is_tima) rdata = tima;
    else if (is_tma)  rdata = tma;
    else if (is_tac)  rdata = {5'b11111, tac};
    else if (is_if)   rdata = {3'b111, if_q};
    else if (is_ie)   rdata = ie;
    else if (is_hram) rdata = hram_rdata;
    else              claimed = 1'b0;
  end

  // Bus outputs are forced idle while reset is asserted.
  assign bus.hit      = claimed & (bus.rd_en | bus.wr_en) & ~rst;
  assign bus.data_out = bus.hit ? rdata : '1;

  // Timer tick source: falling edge of TAC enable ANDed with the selected div bit.
  always_comb begin
    case (tac[1:0])
      2'b00:   sel_bit = div[9];
      2'b01:   sel_bit = div[3];
      2'b10:   sel_bit = div[5];
      default: sel_bit = div[7];
    endcase
    tmr_term  = tac[2] & sel_bit;
    tick      = term_q & ~tmr_term;
    timer_irq = ovf_pend & ~wr_tima;
  end

  // Free-running divider; any write clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         div <= DIV_INIT;
    else if (wr_div) div <= '0;
    else             div <= div + 16'd1;
  end

  // Previous value of the tick term for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) term_q <= 1'b0;
    else     term_q <= tmr_term;
  end

  // TIMA counter with delayed reload; a CPU write beats both tick and reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tima     <= '0;
      ovf_pend <= 1'b0;
    end else begin
      ovf_pend <= 1'b0;
      if (wr_tima) begin
        tima <= bus.data_in;
      end else if (ovf_pend) begin
        tima <= wr_tma ? bus.data_in : tma;
      end else if (tick) begin
        if (tima == 8'hFF) begin
          tima     <= '0;
          ovf_pend <= 1'b1;
        end else begin
          tima <= tima + 8'd1;
        end
      end
    end
  end

  // Plain CPU-written configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tma <= '0;
      tac <= '0;
      ie  <= '0;
    end else begin
      if (wr_tma) tma <= bus.data_in;
      if (wr_tac) tac <= bus.data_in[2:0];
      if (wr_ie)  ie  <= bus.data_in;
    end
  end

  // IF next value: CPU write, then ack clear, then hardware set on top.
  always_comb begin
    hw_set  = {irq_set[4:3], timer_irq, irq_set[1:0]};
    if_next = if_q;
    if (wr_if) if_next = bus.data_in[4:0];
    if_next = (if_next & ~irq_ack) | hw_set;
  end

  // Interrupt flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) if_q <= IF_INIT;
    else     if_q <= if_next;
  end

  assign irq_pending = ie[4:0] & if_q;

endmodule

// File: tb/tb_hram_mmio_responder.sv
// Directed bench for hram_mmio_responder with a queue scoreboard: each read
// issued pushes its expected data/hit/pending; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_hram_mmio_responder;

  logic       clk;
  logic       rst;
  logic [4:0] irq_set;
  logic [4:0] irq_ack;
  logic [4:0] irq_pending;

  hram_mmio_responder_if bus ();

  hram_mmio_responder #(
    .DIV_INIT (16'h0000),
    .IF_INIT  (5'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .irq_set     (irq_set),
    .irq_ack     (irq_ack),
    .irq_pending (irq_pending)
  );

`ifdef HRAM_EN
  localparam bit HRAM = 1'b1;
`else
  localparam bit HRAM = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [7:0] d;
    logic       h;
    logic       cp;
    logic [4:0] p;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every bus cycle with rd_en high is a read response to check.
  always @(negedge clk) begin
    exp_t e;
    if (bus.rd_en) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_underflow: read at %h with no expectation queued", bus.addr_in);
      end else begin
        e = sbq.pop_front();
        n_cmp++;
        if (bus.data_out !== e.d) begin
          n_bad++;
          $display("FAIL %s data: got %h expected %h", e.name, bus.data_out, e.d);
        end
        n_cmp++;
        if (bus.hit !== e.h) begin
          n_bad++;
          $display("FAIL %s hit: got %b expected %b", e.name, bus.hit, e.h);
        end
        if (e.cp) begin
          n_cmp++;
          if (irq_pending !== e.p) begin
            n_bad++;
            $display("FAIL %s irq_pending: got %h expected %h", e.name, irq_pending, e.p);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic push(input string n, input logic [7:0] d, input logic h,
                      input logic cp, input logic [4:0] p);
    exp_t e;
    e.name = n; e.d = d; e.h = h; e.cp = cp; e.p = p;
    sbq.push_back(e);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.addr_in = a; bus.data_in = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input string n, input logic [15:0] a, input logic [7:0] d,
                    input logic h, input logic cp, input logic [4:0] p);
    push(n, d, h, cp, p);
    bus.rd_en = 1'b1; bus.addr_in = a;
    step();
    bus.rd_en = 1'b0;
  endtask

  task automatic rdwr(input string n, input logic [15:0] a, input logic [7:0] wd,
                      input logic [7:0] d, input logic [4:0] p);
    push(n, d, 1'b1, 1'b1, p);
    bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.addr_in = a; bus.data_in = wd;
    step();
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sbq.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; irq_set = '0; irq_ack = '0;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.addr_in = '0; bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rd("in_reset", 16'hFF04, 8'hFF, 1'b0, 1'b1, 5'h00);
    rst = 1'b0;

    // Reset values
    rd("rst_div",  16'hFF04, 8'h00, 1'b1, 1'b0, 5'h00);
    rd("rst_tima", 16'hFF05, 8'h00, 1'b1, 1'b0, 5'h00);
    rd("rst_tac",  16'hFF07, 8'hF8, 1'b1, 1'b0, 5'h00);
    rd("rst_if",   16'hFF0F, 8'hE0, 1'b1, 1'b1, 5'h00);
    rd("rst_ie",   16'hFFFF, 8'h00, 1'b1, 1'b0, 5'h00);

    // HRAM and decode boundaries
    wr(16'hFF80, 8'h5A);
    wr(16'hFFFE, 8'hC3);
    rd("hram_ff80", 16'hFF80, HRAM ? 8'h5A : 8'hFF, HRAM, 1'b0, 5'h00);
    rd("hram_fffe", 16'hFFFE, HRAM ? 8'hC3 : 8'hFF, HRAM, 1'b0, 5'h00);
    rd("miss_ff7f", 16'hFF7F, 8'hFF, 1'b0, 1'b0, 5'h00);
    rd("miss_ff08", 16'hFF08, 8'hFF, 1'b0, 1'b0, 5'h00);
    rd("ie_untouched", 16'hFFFF, 8'h00, 1'b1, 1'b0, 5'h00);

    // Simultaneous rd/wr shows the pre-write value
    rdwr("rdwr_tma", 16'hFF06, 8'h77, 8'h00, 5'h00);
    rd("tma_after", 16'hFF06, 8'h77, 1'b1, 1'b0, 5'h00);

    // Overflow and reload: TAC=101 (div[3]), TMA=F0, TIMA=FE
    wr(16'hFFFF, 8'h04);
    wr(16'hFF06, 8'hF0);
    wr(16'hFF07, 8'h05);
    wr(16'hFF04, 8'h00);
    wr(16'hFF05, 8'hFE);
    rd("tima_fe_a", 16'hFF05, 8'hFE, 1'b1, 1'b0, 5'h00);
    idle(14);
    rd("tima_fe_b", 16'hFF05, 8'hFE, 1'b1, 1'b0, 5'h00);
    rd("tima_ff_a", 16'hFF05, 8'hFF, 1'b1, 1'b0, 5'h00);
    idle(14);
    rd("tima_ff_b", 16'hFF05, 8'hFF, 1'b1, 1'b0, 5'h00);
    rd("tima_ovf00", 16'hFF05, 8'h00, 1'b1, 1'b1, 5'h00);
    rd("tima_reload", 16'hFF05, 8'hF0, 1'b1, 1'b1, 5'h04);
    rd("if_timer", 16'hFF0F, 8'hE4, 1'b1, 1'b1, 5'h04);
    wr(16'hFF0F, 8'h00);
    rd("if_cleared", 16'hFF0F, 8'hE0, 1'b1, 1'b1, 5'h00);

    // TIMA write in the reload cycle cancels reload and IF[2]
    wr(16'hFF04, 8'h00);
    wr(16'hFF05, 8'hFF);
    idle(16);
    rdwr("cancel_00", 16'hFF05, 8'h10, 8'h00, 5'h00);
    rd("cancel_tima", 16'hFF05, 8'h10, 1'b1, 1'b1, 5'h00);
    rd("cancel_if", 16'hFF0F, 8'hE0, 1'b1, 1'b1, 5'h00);

    // TMA written in the reload cycle is the value loaded
    wr(16'hFF04, 8'h00);
    wr(16'hFF05, 8'hFF);
    idle(16);
    wr(16'hFF06, 8'h33);
    rd("reload_new_tma", 16'hFF05, 8'h33, 1'b1, 1'b1, 5'h04);
    wr(16'hFF0F, 8'h00);

    // DIV reaches 1234, write clears it; div[9] drop ticks TIMA (TAC=100)
    wr(16'hFF07, 8'h04);
    wr(16'hFF04, 8'h00);
    idle(32'h122F);
    wr(16'hFF05, 8'h40);
    idle(3);
    rd("tima_40", 16'hFF05, 8'h40, 1'b1, 1'b0, 5'h00);
    rdwr("div_1234", 16'hFF04, 8'hAB, 8'h12, 5'h00);
    rd("div_cleared", 16'hFF04, 8'h00, 1'b1, 1'b0, 5'h00);
    rd("div_wr_tick", 16'hFF05, 8'h41, 1'b1, 1'b0, 5'h00);

    // IF priorities
    wr(16'hFFFF, 8'h1F);
    irq_set = 5'h01; irq_ack = 5'h01;
    step();
    irq_set = 5'h00;
    rd("set_beats_ack", 16'hFF0F, 8'hE1, 1'b1, 1'b1, 5'h01);
    irq_ack = 5'h00;
    rd("ack_clears", 16'hFF0F, 8'hE0, 1'b1, 1'b1, 5'h00);
    irq_ack = 5'h02;
    wr(16'hFF0F, 8'h1F);
    irq_ack = 5'h00;
    rd("ack_beats_wr", 16'hFF0F, 8'hFD, 1'b1, 1'b1, 5'h1D);
    wr(16'hFF0F, 8'h00);
    irq_set = 5'h04;
    step();
    irq_set = 5'h00;
    rd("set2_ignored", 16'hFF0F, 8'hE0, 1'b1, 1'b1, 5'h00);
    irq_set = 5'h10;
    wr(16'hFF0F, 8'h00);
    irq_set = 5'h00;
    rd("set_beats_wr", 16'hFF0F, 8'hF0, 1'b1, 1'b1, 5'h10);
    wr(16'hFFFF, 8'hA5);
    rd("ie_full8", 16'hFFFF, 8'hA5, 1'b1, 1'b1, 5'h00);
    irq_set = 5'h01;
    step();
    irq_set = 5'h00;
    rd("pend_pre_rst", 16'hFF0F, 8'hF1, 1'b1, 1'b1, 5'h01);

    // Asynchronous reset mid-count, visible before any clock edge
    push("async_rst", 8'hFF, 1'b0, 1'b1, 5'h00);
    bus.rd_en = 1'b1; bus.addr_in = 16'hFF07;
    #2 rst = 1'b1;
    step();
    bus.rd_en = 1'b0;
    rst = 1'b0;
    rd("post_tima", 16'hFF05, 8'h00, 1'b1, 1'b0, 5'h00);
    rd("post_tac",  16'hFF07, 8'hF8, 1'b1, 1'b0, 5'h00);
    rd("post_ie",   16'hFFFF, 8'h00, 1'b1, 1'b0, 5'h00);
    rd("post_if",   16'hFF0F, 8'hE0, 1'b1, 1'b1, 5'h00);
    rd("post_tma",  16'hFF06, 8'h00, 1'b1, 1'b0, 5'h00);
    rd("post_div",  16'hFF04, 8'h00, 1'b1, 1'b0, 5'h00);

    idle(2);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d entries left expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hram_mmio_responder.md
Name: hram_mmio_responder

Overview:
- Bus responder on the CPU's single-master bus (rd_en / wr_en / 16-bit address / 8-bit data).
- Claims the high I/O page: timer registers FF04–FF07, interrupt flags IF at FF0F, high RAM FF80–FFFE and interrupt enable IE at FFFF.
- Returns read data combinationally in the same cycle, because the CPU samples read data on the clock edge that ends the bus cycle.
- Owns the DIV/TIMA timer and IF/IE state, and presents pending interrupts to the control unit.

Parameters:
- DIV_INIT, 16'h0000, reset value of the internal 16-bit divider counter.
- IF_INIT, 5'h00, reset value of IF[4:0].

Ports:
- clk  in  1  system clock (one M-cycle per clk).
- rst  in  1  asynchronous, active-high reset.
- rd_en  in  1  CPU read strobe.
- wr_en  in  1  CPU write strobe.
- addr_in  in  16  CPU address.
- data_in  in  8  CPU write data.
- data_out  out  8  read data; 8'hFF when not hit.
- hit  out  1  address is claimed by this block and (rd_en|wr_en); combinational.
- irq_set  in  5  one-cycle pulses from other peripherals (VBlank, STAT, Serial, Joypad bits); bit 2 is ignored (timer is internal).
- irq_ack  in  5  one-hot clear of an IF bit when the CPU services an interrupt.
- irq_pending  out  5  IE[4:0] & IF[4:0], combinational.

Behaviour:
- Reset (async, active-high): div=DIV_INIT, TIMA=0, TMA=0, TAC=0, IF=IF_INIT, IE=0, overflow_pend=0.
- Reset: HRAM contents are undefined (not reset).
- Reset: data_out=FF, hit=0.
- Address decode:
  - FF04 DIV: reads div[15:8].
  - FF05 TIMA.
  - FF06 TMA.
  - FF07 TAC: reads {5'b11111, TAC[2:0]}.
  - FF0F IF: reads {3'b111, IF}.
  - FF80–FFFE HRAM: 127 bytes, index addr_in[6:0].
  - FFFF IE: reads the full 8 bits stored; only bits [4:0] feed irq_pending.
  - Everything else: hit=0, data_out=FF, writes ignored.
- Reads are combinational from current register state and have no side effects.
- Writes commit on the rising clk edge while wr_en=1.
- rd_en and wr_en both high: treated as a write; data_out still shows the pre-write value.
- Divider: div increments by 1 every clk.
  - Write to DIV (any data) sets div=0 on that edge.
- TIMA tick source: sel = div bit 9, 3, 5, 7 for TAC[1:0] = 00, 01, 10, 11.
  - tick = falling edge of (TAC[2] & sel), using a registered previous value.
  - Consequently a DIV write or a TAC change that drops the term from 1 to 0 produces a tick.
- TIMA overflow:
  - Tick at TIMA=FF: TIMA becomes 00 and overflow_pend=1.
  - Next cycle: TIMA=TMA, IF[2] set, overflow_pend cleared.
  - If TMA is written in that reload cycle, the new TMA value is loaded.
  - CPU write to TIMA while overflow_pend=1: cancels the reload and the IF[2] set; the written value is kept.
  - CPU write to TIMA coinciding with a tick: the write wins.
- IF update priority, per bit, highest first:
  1. Hardware set (irq_set, or the timer for bit 2).
  2. irq_ack clear.
  3. CPU write.
  - Other bits follow the CPU write if one occurs.
- irq_pending reflects the register values after the edge, so there is 1 clk latency from an irq_set pulse.

Optional Feature:
- Macro HRAM_EN.
  - Defined: HRAM implemented as above.
  - Undefined: no HRAM storage; FF80–FFFE gives hit=0, reads FF and writes are dropped.
  - IE, IF and timer behaviour are unchanged either way.

Test Plan:
- Write 8'h5A to FF80 and 8'hC3 to FFFE, read back -> 5A and C3 with hit=1; read FF7F -> hit=0, data_out=FF (without HRAM_EN, FF80 also reads FF).
- TAC=3'b101, TMA=8'hF0, TIMA=8'hFE -> TIMA increments every 16 clks; after FF one cycle reads 00, then F0; IF[2]=1; with IE=04, irq_pending=04.
- Same setup, write TIMA=8'h10 during the 00 cycle -> TIMA stays 10, IF[2] stays 0.
- Let div reach 16'h1234, then write DIV -> DIV reads 00 the next cycle; with TAC=3'b100 and div[9]=1 beforehand, TIMA increments by 1.
- irq_set=01 and irq_ack=01 in the same cycle -> IF[0]=1; irq_ack=01 alone the next cycle -> IF[0]=0; IF reads E0.
- Assert rst asynchronously mid-count -> all outputs and registers return to their reset values immediately, with no clk edge needed.
